// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with one-deep registered output stage
module instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [15:0]       err_cnt
);

    localparam logic [2:0]  FMT_I = 3'd0;
    localparam logic [2:0]  FMT_S = 3'd1;
    localparam logic [2:0]  FMT_B = 3'd2;
    localparam logic [2:0]  FMT_J = 3'd3;
    localparam logic [2:0]  FMT_R = 3'd4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       packed_word;
    logic              field_err;
    logic              accept;

    // A signed value fits in N bits when all bits from N-1 upward agree
    logic fits_12, fits_13, fits_21;
    assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Pack the fields per format and flag immediates the format cannot express
    always_comb begin
        packed_word = NOP;
        field_err   = 1'b0;
        unique case (in_fmt)
            FMT_I: begin
                packed_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                field_err   = !fits_12;
            end
            FMT_S: begin
                packed_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                field_err   = !fits_12;
            end
            FMT_B: begin
                packed_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
                field_err   = !fits_13 || in_imm[0];
            end
            FMT_J: begin
                packed_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, in_opcode};
                field_err   = !fits_21 || in_imm[0];
            end
            FMT_R: begin
                packed_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                field_err   = 1'b0;
            end
            default: begin
                packed_word = NOP;
                field_err   = 1'b1;
            end
        endcase
    end

    // Output register, address counter and saturating error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            out_addr  <= BASE_ADDR;
            addr_cnt  <= BASE_ADDR;
            err_cnt   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            addr_cnt  <= BASE_ADDR;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= field_err ? NOP : packed_word;
            out_err   <= field_err;
            out_addr  <= addr_cnt;
            addr_cnt  <= addr_cnt + ADDR_W'(4);
            if (field_err && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // Advance one edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        err;
    } bound_t;

    bound_t bounds[10] = '{
        '{3'd0, 32'hFFFF_F800, 1'b0},   // I -2048
        '{3'd0, 32'h0000_07FF, 1'b0},   // I 2047
        '{3'd1, 32'hFFFF_F7FF, 1'b1},   // S -2049
        '{3'd2, 32'h0000_0FFE, 1'b0},   // B 4094
        '{3'd2, 32'hFFFF_F000, 1'b0},   // B -4096
        '{3'd2, 32'h0000_1000, 1'b1},   // B 4096
        '{3'd3, 32'h000F_FFFE, 1'b0},   // J 1048574
        '{3'd3, 32'h0010_0000, 1'b1},   // J 1048576
        '{3'd3, 32'hFFF0_0000, 1'b0},   // J -1048576
        '{3'd3, 32'h0000_0801, 1'b1}    // J odd
    };

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_fields(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        check("rst_cnt", {16'd0, err_cnt}, 32'd0);
        check("rst_addr", out_addr, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);

        // I: addi x1,x0,5
        set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("i_valid", {31'd0, out_valid}, 32'd1);
        check("i_instr", out_instr, 32'h0050_0093);
        check("i_addr", out_addr, 32'h0);
        check("i_err", {31'd0, out_err}, 32'd0);
        step();
        check("i_drain", {31'd0, out_valid}, 32'd0);

        // S then R back-to-back, then B and J
        do_flush();
        in_valid = 1'b1;
        set_fields(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        step();
        check("s_instr", out_instr, 32'h0020_A423);
        check("s_addr", out_addr, 32'h0);
        set_fields(3'd4, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
        step();
        check("r_valid", {31'd0, out_valid}, 32'd1);
        check("r_instr", out_instr, 32'h0020_81B3);
        check("r_addr", out_addr, 32'h4);
        set_fields(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        step();
        check("b_instr", out_instr, 32'hFE00_0EE3);
        check("b_addr", out_addr, 32'h8);
        set_fields(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        step();
        check("j_instr", out_instr, 32'h0010_00EF);
        check("j_addr", out_addr, 32'hC);
        in_valid = 1'b0;
        step();

        // Error substitutions
        do_flush();
        in_valid = 1'b1;
        set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        step();
        check("e1_instr", out_instr, 32'h0000_0013);
        check("e1_err", {31'd0, out_err}, 32'd1);
        check("e1_cnt", {16'd0, err_cnt}, 32'd1);
        check("e1_addr", out_addr, 32'h0);
        set_fields(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        step();
        check("e2_instr", out_instr, 32'h0000_0013);
        check("e2_cnt", {16'd0, err_cnt}, 32'd2);
        check("e2_addr", out_addr, 32'h4);
        set_fields(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        check("e3_instr", out_instr, 32'h0000_0013);
        check("e3_cnt", {16'd0, err_cnt}, 32'd3);
        check("e3_addr", out_addr, 32'h8);

        // Range boundaries
        foreach (bounds[i]) begin
            set_fields(bounds[i].fmt, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, bounds[i].imm);
            step();
            check($sformatf("bound%0d_err", i), {31'd0, out_err}, {31'd0, bounds[i].err});
        end
        in_valid = 1'b0;
        step();

        // Backpressure: first word held while out_ready is low
        do_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_fields(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        step();
        set_fields(3'd4, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d_instr", c), out_instr, 32'h0050_0093);
            check($sformatf("bp%0d_addr", c), out_addr, 32'h0);
            check($sformatf("bp%0d_ready", c), {31'd0, in_ready}, 32'd0);
            step();
        end

        // Flush with a simultaneous input: input dropped, output cleared
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        check("fl_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        set_fields(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        step();
        in_valid = 1'b0;
        check("fl_next_instr", out_instr, 32'h0020_A423);
        check("fl_next_addr", out_addr, 32'h0);
        check("fl_cnt_kept", {16'd0, err_cnt}, 32'd7);

        // Asynchronous reset while a word is held
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_instr", out_instr, 32'd0);
        check("ar_addr", out_addr, 32'd0);
        check("ar_cnt", {16'd0, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Saturation of the error counter
        in_valid = 1'b1;
        set_fields(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        repeat (65539) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sat_cnt", {16'd0, err_cnt}, 32'h0000_FFFF);
        check("sat_err", {31'd0, out_err}, 32'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
